lsu_pipe: RTL and testbench

LSU_PIPE -- requirements
Module: lsu_pipe

---
 rtl/lsu_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_lsu_pipe.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_pipe.sv
// lsu_pipe: three-state load/store unit over a word-addressed data memory and I/O registers.
// Optional macro LSU_PIPE_SYNC_EN inserts a 2-flop synchronizer on every io_in_i channel.
module lsu_pipe #(
    parameter int unsigned DMEM_AW = 9,
    parameter int unsigned OUT_CH  = 11,
    parameter int unsigned IN_CH   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 ready_o,
    input  logic                 we_i,
    input  logic [2:0]           funct3_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          st_data_i,
    output logic                 valid_o,
    output logic [31:0]          ld_data_o,
    output logic                 err_o,
    input  logic [IN_CH*32-1:0]  io_in_i,
    output logic [OUT_CH*32-1:0] io_out_o
);

    localparam int unsigned DmemWords = 1 << DMEM_AW;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         st_data_q, st_data_d;
    logic [31:0]         out_q [OUT_CH];
    logic [31:0]         out_d [OUT_CH];
    logic [31:0]         io_rdata_q, io_rdata_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [31:0]         ld_data_q, ld_data_d;
    logic [31:0]         mem_rdata_q;
    logic [31:0]         mem [DmemWords];
    logic [IN_CH*32-1:0] in_bus;

`ifdef LSU_PIPE_SYNC_EN
    logic [IN_CH*32-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= io_in_i;
            sync2_q <= sync1_q;
        end
    end

    assign in_bus = sync2_q;
`else
    assign in_bus = io_in_i;
`endif

    // Decode of the latched request
    logic [5:0]         ch;
    logic               is_data, is_out, is_in, legal, misaligned, err;
    logic [3:0]         be;
    logic [31:0]        wdata, word, lane, ext;
    logic [DMEM_AW-1:0] mem_idx;
    logic               wr_en;

    always_comb begin
        ch      = addr_q[7:2];
        mem_idx = addr_q[DMEM_AW+1:2];
        is_data = (addr_q[31:12] == 20'd0) && !addr_q[11] &&
                  (({21'b0, addr_q[10:0]} >> (DMEM_AW + 2)) == 32'd0);
        is_out  = (addr_q[31:12] == 20'd0) && (addr_q[11:8] == 4'h8) && (32'(ch) < OUT_CH);
        is_in   = (addr_q[31:12] == 20'd0) && (addr_q[11:8] == 4'h9) && (32'(ch) < IN_CH);
        case (funct3_q)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !we_q;
            default:                legal = 1'b0;
        endcase
        misaligned = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        err = !legal || misaligned || !(is_data || is_out || (is_in && !we_q));
        case (funct3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wdata = {4{st_data_q[7:0]}};
            end
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data_q;
            end
        endcase
        wr_en = (state_q == StAccess) && we_q && !err;
        word  = is_data ? mem_rdata_q : io_rdata_q;
        lane  = word >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext = {24'b0, lane[7:0]};
            3'b101:  ext = {16'b0, lane[15:0]};
            default: ext = word;
        endcase
    end

    // Memory has no reset; contents survive rst_i
    always_ff @(posedge clk_i) begin
        if (state_q == StAccess && !rst_i) begin
            if (wr_en && is_data) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            mem_rdata_q <= mem[mem_idx];
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        st_data_d  = st_data_q;
        out_d      = out_q;
        io_rdata_d = io_rdata_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        ld_data_d  = '0;
        case (state_q)
            StIdle: begin
                if (req_i) begin
                    we_d      = we_i;
                    funct3_d  = funct3_i;
                    addr_d    = addr_i;
                    st_data_d = st_data_i;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                for (int k = 0; k < OUT_CH; k++) begin
                    if (is_out && ch == 6'(k)) begin
                        io_rdata_d = out_q[k];
                        if (wr_en) begin
                            for (int b = 0; b < 4; b++) begin
                                if (be[b]) out_d[k][8*b +: 8] = wdata[8*b +: 8];
                            end
                        end
                    end
                end
                for (int k = 0; k < IN_CH; k++) begin
                    if (is_in && ch == 6'(k)) io_rdata_d = in_bus[32*k +: 32];
                end
                state_d = StResp;
            end
            StResp: begin
                valid_d   = 1'b1;
                err_d     = err;
                ld_data_d = (err || we_q) ? 32'd0 : ext;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            st_data_q  <= '0;
            io_rdata_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ld_data_q  <= '0;
            for (int k = 0; k < OUT_CH; k++) out_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            st_data_q  <= st_data_d;
            io_rdata_q <= io_rdata_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ld_data_q  <= ld_data_d;
            out_q      <= out_d;
        end
    end

    always_comb begin
        for (int k = 0; k < OUT_CH; k++) io_out_o[32*k +: 32] = out_q[k];
    end

    assign ready_o   = (state_q == StIdle);
    assign valid_o   = valid_q;
    assign err_o     = err_q;
    assign ld_data_o = ld_data_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// Self-checking bench for lsu_pipe: directed scenarios plus random traffic against a
// byte-level reference model of memory and I/O registers.
module tb_lsu_pipe;

    localparam int unsigned DMEM_AW = 9;
    localparam int unsigned OUT_CH  = 11;
    localparam int unsigned IN_CH   = 2;
    localparam int unsigned DW      = 1 << DMEM_AW;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 req_i = 1'b0;
    logic                 ready_o;
    logic                 we_i = 1'b0;
    logic [2:0]           funct3_i = '0;
    logic [31:0]          addr_i = '0;
    logic [31:0]          st_data_i = '0;
    logic                 valid_o;
    logic [31:0]          ld_data_o;
    logic                 err_o;
    logic [IN_CH*32-1:0]  io_in_i = '0;
    logic [OUT_CH*32-1:0] io_out_o;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_mem [DW*4];
    logic [31:0] m_out [OUT_CH];
    logic [31:0] m_in  [IN_CH];

    lsu_pipe #(.DMEM_AW(DMEM_AW), .OUT_CH(OUT_CH), .IN_CH(IN_CH)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .ready_o   (ready_o),
        .we_i      (we_i),
        .funct3_i  (funct3_i),
        .addr_i    (addr_i),
        .st_data_i (st_data_i),
        .valid_o   (valid_o),
        .ld_data_o (ld_data_o),
        .err_o     (err_o),
        .io_in_i   (io_in_i),
        .io_out_o  (io_out_o)
    );

    always #5 clk = ~clk;

    // Reference: byte-granular view of the address map, little-endian.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] sd, output logic [31:0] ld,
                                  output logic er);
        int n;
        int region;
        int unsigned ch;
        logic [31:0] w;
        ld = '0; er = 1'b0; ch = 0; w = '0;
        case (f3)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        if (n == 0 || (we && f3[2])) er = 1'b1;
        else if ((a % n) != 0) er = 1'b1;
        region = -1;
        if (a < 32'h800) begin
            if (a / 4 < DW) region = 0;
        end else if (a < 32'h900) begin
            ch = (a - 32'h800) / 4;
            if (ch < OUT_CH) region = 1;
        end else if (a < 32'hA00) begin
            ch = (a - 32'h900) / 4;
            if (ch < IN_CH && !we) region = 2;
        end
        if (region < 0) er = 1'b1;
        if (er) return;
        for (int i = 0; i < n; i++) begin
            int unsigned off;
            off = (a % 4) + i;
            if (we) begin
                if (region == 0) m_mem[a + i] = sd[8*i +: 8];
                else m_out[ch][8*off +: 8] = sd[8*i +: 8];
            end else begin
                if (region == 0) w[8*i +: 8] = m_mem[a + i];
                else if (region == 1) w[8*i +: 8] = m_out[ch][8*off +: 8];
                else w[8*i +: 8] = m_in[ch][8*off +: 8];
            end
        end
        if (we) ld = '0;
        else if (n == 1) ld = f3[2] ? {24'b0, w[7:0]} : {{24{w[7]}}, w[7:0]};
        else if (n == 2) ld = f3[2] ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
        else ld = w;
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, output logic [31:0] ld, output logic er,
                          output int lat, output logic stray);
        int n;
        @(negedge clk);
        n = 0;
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; st_data_i = sd;
        @(posedge clk);
        #1 req_i = 1'b0;
        stray = 1'b0;
        for (lat = 1; lat <= 10; lat++) begin
            @(posedge clk);
            #1;
            if (valid_o) break;
            if (ld_data_o !== 32'd0 || err_o !== 1'b0) stray = 1'b1;
        end
        ld = ld_data_o;
        er = err_o;
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, output logic [31:0] ld, output logic er,
                       output int lat, output logic stray, output logic [31:0] exp_ld,
                       output logic exp_er);
        model(we, f3, a, sd, exp_ld, exp_er);
        do_req(we, f3, a, sd, ld, er, lat, stray);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || err_o !== 1'b0 || ld_data_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b ld=%h, required 1 0 0 0",
                     ready_o, valid_o, err_o, ld_data_o);
        end
        checks++;
        if (io_out_o !== '0) begin
            errors++;
            $display("FAIL reset_io_out: got %h, required 0", io_out_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", ready_o);
        end
        for (int k = 0; k < OUT_CH; k++) m_out[k] = '0;
    endtask

    task automatic test_fill;
        logic [31:0] ld, eld;
        logic er, eer, stray;
        int lat, bad;
        bad = 0;
        for (int w = 0; w < DW; w++) begin
            run(1'b1, 3'd2, 32'(w) * 4, $urandom, ld, er, lat, stray, eld, eer);
            if (er !== 1'b0 || lat != 2) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fill_stores: %0d bad responses, required 0", bad);
        end
    endtask

    task automatic test_load_ext;
        logic [31:0] ld, eld;
        logic er, eer, stray;
        int lat;
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] as  [4] = '{32'h013, 32'h013, 32'h012, 32'h012};
        logic [31:0] exs [4] = '{32'hFFFF_FF87, 32'h0000_0087, 32'hFFFF_8765, 32'h0000_8765};
        run(1'b1, 3'd2, 32'h010, 32'h8765_4321, ld, er, lat, stray, eld, eer);
        checks++;
        if (er !== 1'b0 || ld !== 32'd0 || lat != 2) begin
            errors++;
            $display("FAIL sw_0x010: err=%b ld=%h lat=%0d, required 0 0 2", er, ld, lat);
        end
        for (int i = 0; i < 4; i++) begin
            run(1'b0, f3s[i], as[i], 32'd0, ld, er, lat, stray, eld, eer);
            checks++;
            if (ld !== exs[i] || er !== 1'b0 || lat != 2) begin
                errors++;
                $display("FAIL load_ext_%0d: ld=%h err=%b lat=%0d, required %h 0 2",
                         i, ld, er, lat, exs[i]);
            end
        end
    endtask

    task automatic test_byte_store;
        logic [31:0] ld, eld;
        logic er, eer, stray;
        int lat;
        run(1'b1, 3'd2, 32'h020, 32'h0, ld, er, lat, stray, eld, eer);
        run(1'b1, 3'd0, 32'h021, 32'hFFFF_FFAB, ld, er, lat, stray, eld, eer);
        run(1'b0, 3'd2, 32'h020, 32'h0, ld, er, lat, stray, eld, eer);
        checks++;
        if (ld !== 32'h0000_AB00 || er !== 1'b0) begin
            errors++;
            $display("FAIL sb_then_lw: ld=%h err=%b, required 0000ab00 0", ld, er);
        end
    endtask

    task automatic test_errors;
        logic [31:0] ld, eld;
        logic er, eer, stray;
        int lat;
        logic        wes [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [3] = '{3'd2, 3'd1, 3'd2};
        logic [31:0] as  [3] = '{32'h006, 32'h003, 32'hA00};
        for (int i = 0; i < 3; i++) begin
            run(wes[i], f3s[i], as[i], 32'hFFFF_FFFF, ld, er, lat, stray, eld, eer);
            checks++;
            if (er !== 1'b1 || ld !== 32'd0 || lat != 2) begin
                errors++;
                $display("FAIL err_case_%0d: err=%b ld=%h lat=%0d, required 1 0 2", i, er, ld, lat);
            end
        end
        for (int i = 0; i < 2; i++) begin
            run(1'b0, 3'd2, 32'(i) * 4, 32'd0, ld, er, lat, stray, eld, eer);
            checks++;
            if (ld !== eld || er !== 1'b0) begin
                errors++;
                $display("FAIL err_mem_unchanged_%0d: ld=%h err=%b, required %h 0", i, ld, er, eld);
            end
        end
    endtask

    task automatic test_io_out;
        logic [31:0] ld, eld;
        logic er, eer, stray;
        int lat;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h800; st_data_i = 32'hFF;
        model(1'b1, 3'd2, 32'h800, 32'hFF, eld, eer);
        @(posedge clk);
        #1 req_i = 1'b0;
        checks++;
        if (io_out_o[31:0] !== 32'd0) begin
            errors++;
            $display("FAIL io_out_before_access: got %h, required 0", io_out_o[31:0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (io_out_o[31:0] !== 32'hFF) begin
            errors++;
            $display("FAIL io_out_at_access: got %h, required ff", io_out_o[31:0]);
        end
        lat = 0;
        while (!valid_o && lat < 5) begin
            @(posedge clk);
            #1 lat++;
        end
        checks++;
        if (valid_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL io_out_resp: valid=%b err=%b, required 1 0", valid_o, err_o);
        end
        run(1'b1, 3'd2, 32'h82C, 32'h1, ld, er, lat, stray, eld, eer);
        checks++;
        if (er !== 1'b1 || ld !== 32'd0) begin
            errors++;
            $display("FAIL io_out_ch11: err=%b ld=%h, required 1 0", er, ld);
        end
    endtask

    task automatic test_io_in;
        logic [31:0] ld, eld;
        logic er, eer, stray;
        int lat;
        @(negedge clk);
        io_in_i[63:32] = 32'h1234;
        m_in[1] = 32'h1234;
        repeat (3) @(posedge clk);
        run(1'b0, 3'd2, 32'h904, 32'd0, ld, er, lat, stray, eld, eer);
        checks++;
        if (ld !== 32'h1234 || er !== 1'b0) begin
            errors++;
            $display("FAIL io_in_ch1: ld=%h err=%b, required 00001234 0", ld, er);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] eld;
        logic eer;
        int nvalid, badpos, badld;
        model(1'b0, 3'd2, 32'h010, 32'd0, eld, eer);
        nvalid = 0; badpos = 0; badld = 0;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h010;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) begin
                nvalid++;
                if (i % 3 != 2) badpos++;
                if (ld_data_o !== eld) badld++;
            end
        end
        req_i = 1'b0;
        checks++;
        if (nvalid != 5 || badpos != 0) begin
            errors++;
            $display("FAIL b2b_rate: valids=%0d misplaced=%0d, required 5 0", nvalid, badpos);
        end
        checks++;
        if (badld != 0) begin
            errors++;
            $display("FAIL b2b_data: %0d wrong loads, required 0 (expected %h)", badld, eld);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_abort;
        logic [31:0] ld, eld;
        logic er, eer, stray;
        int lat, seen;
        logic [31:0] as [2] = '{32'h800, 32'h040};
        for (int t = 0; t < 2; t++) begin
            seen = 0;
            @(negedge clk);
            req_i = 1'b1; we_i = 1'b1; funct3_i = 3'd2; addr_i = as[t]; st_data_i = 32'h5A5A_5A5A;
            @(posedge clk);
            #2 req_i = 1'b0;
            rst_i = 1'b1;
            for (int i = 0; i < 2; i++) begin
                @(posedge clk);
                #1 if (valid_o) seen++;
            end
            @(negedge clk);
            rst_i = 1'b0;
            #1;
            checks++;
            if (ready_o !== 1'b1) begin
                errors++;
                $display("FAIL abort_ready_%0d: got %b, required 1", t, ready_o);
            end
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1 if (valid_o) seen++;
            end
            checks++;
            if (seen != 0 || io_out_o !== '0) begin
                errors++;
                $display("FAIL abort_%0d: valids=%0d io_out=%h, required 0 0", t, seen, io_out_o);
            end
        end
        for (int k = 0; k < OUT_CH; k++) m_out[k] = '0;
        run(1'b0, 3'd2, 32'h040, 32'd0, ld, er, lat, stray, eld, eer);
        checks++;
        if (ld !== eld || er !== 1'b0) begin
            errors++;
            $display("FAIL abort_mem_unchanged: ld=%h err=%b, required %h 0", ld, er, eld);
        end
    endtask

    task automatic test_random;
        logic [31:0] ld, eld, a, sd;
        logic er, eer, stray, we;
        logic [2:0] f3;
        logic [OUT_CH*32-1:0] exp_io;
        int lat, kind;
        @(negedge clk);
        for (int k = 0; k < IN_CH; k++) begin
            m_in[k] = $urandom;
            io_in_i[32*k +: 32] = m_in[k];
        end
        repeat (3) @(posedge clk);
        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3, 4: a = 32'($urandom_range(0, DW - 1)) * 4;
                5, 6: a = 32'h800 + 32'($urandom_range(0, 63)) * 4;
                7: a = 32'h900 + 32'($urandom_range(0, 63)) * 4;
                8: a = 32'($urandom_range(32'hA00, 32'hFFF));
                default: a = $urandom;
            endcase
            if (kind < 8) a = a + 32'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            sd = $urandom;
            run(we, f3, a, sd, ld, er, lat, stray, eld, eer);
            checks++;
            if (ld !== eld || er !== eer) begin
                errors++;
                $display("FAIL rand_%0d we=%b f3=%0d a=%h: ld=%h err=%b, required %h %b",
                         t, we, f3, a, ld, er, eld, eer);
            end
            checks++;
            if (lat != 2 || stray !== 1'b0) begin
                errors++;
                $display("FAIL rand_timing_%0d: lat=%0d stray=%b, required 2 0", t, lat, stray);
            end
            for (int k = 0; k < OUT_CH; k++) exp_io[32*k +: 32] = m_out[k];
            checks++;
            if (io_out_o !== exp_io) begin
                errors++;
                $display("FAIL rand_io_out_%0d: got %h, required %h", t, io_out_o, exp_io);
            end
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_load_ext;
        test_byte_store;
        test_errors;
        test_io_out;
        test_io_in;
        test_back_to_back;
        test_reset_abort;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
